// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared mode and direction types for the up/down counter
package contador_pkg;

  // Count mode as carried on the bus; MODO_RESERVADO behaves as a pause.
  typedef enum logic [1:0] {
    MODO_CRESCENTE   = 2'b00,
    MODO_DECRESCENTE = 2'b01,
    MODO_VAI_E_VEM   = 2'b10,
    MODO_RESERVADO   = 2'b11
  } modo_t;

  // Encoding of the direcao output.
  localparam logic DIR_SOBE  = 1'b1;
  localparam logic DIR_DESCE = 1'b0;

endpackage

// File: rtl/contador_crescente_decrescente_param_if.sv
// rtl/contador_crescente_decrescente_param_if.sv - counter control/status bus (load signals only with CONTADOR_CARGA_EN)
interface contador_crescente_decrescente_param_if
  import contador_pkg::*;
#(
  parameter int LARGURA = 4
);

  logic               habilita;
  modo_t              modo;
`ifdef CONTADOR_CARGA_EN
  logic               carga;
  logic [LARGURA-1:0] valor_carga;
`endif
  logic [LARGURA-1:0] saida;
  logic               direcao;
  logic               fim;

  // Controller side: drives enable/mode/load, observes the count.
  modport master (
`ifdef CONTADOR_CARGA_EN
    output carga, valor_carga,
`endif
    output habilita, modo,
    input  saida, direcao, fim
  );

  // Counter side.
  modport slave (
`ifdef CONTADOR_CARGA_EN
    input  carga, valor_carga,
`endif
    input  habilita, modo,
    output saida, direcao, fim
  );

endinterface

// File: rtl/contador_proximo.sv
// rtl/contador_proximo.sv - combinational next count, direction and terminal flag
module contador_proximo
  import contador_pkg::*;
#(
  parameter int LARGURA    = 4,
  parameter int LIMITE_MIN = 0,
  parameter int LIMITE_MAX = 2**LARGURA - 1
) (
  input  logic [LARGURA-1:0] i_saida,
  input  logic               i_direcao,
  input  logic               i_habilita,
  input  modo_t              i_modo,
  output logic [LARGURA-1:0] o_saida,
  output logic               o_direcao,
  output logic               o_fim
);

  localparam logic [LARGURA-1:0] L_MIN = LARGURA'(LIMITE_MIN);
  localparam logic [LARGURA-1:0] L_MAX = LARGURA'(LIMITE_MAX);
  localparam logic [LARGURA-1:0] UM    = LARGURA'(1);

  // Next state: hold by default; bounds use >=/<= so a stray value still folds back into range.
  always_comb begin
    o_saida   = i_saida;
    o_direcao = i_direcao;
    o_fim     = 1'b0;
    if (i_habilita) begin
      case (i_modo)
        MODO_CRESCENTE: begin
          o_direcao = DIR_SOBE;
          if (i_saida >= L_MAX) begin
            o_saida = L_MIN;
            o_fim   = 1'b1;
          end else begin
            o_saida = i_saida + UM;
          end
        end
        MODO_DECRESCENTE: begin
          o_direcao = DIR_DESCE;
          if (i_saida <= L_MIN) begin
            o_saida = L_MAX;
            o_fim   = 1'b1;
          end else begin
            o_saida = i_saida - UM;
          end
        end
        MODO_VAI_E_VEM: begin
          if (i_direcao == DIR_SOBE) begin
            if (i_saida >= L_MAX) begin
              o_saida   = L_MAX - UM;
              o_direcao = DIR_DESCE;
              o_fim     = 1'b1;
            end else begin
              o_saida = i_saida + UM;
            end
          end else begin
            if (i_saida <= L_MIN) begin
              o_saida   = L_MIN + UM;
              o_direcao = DIR_SOBE;
              o_fim     = 1'b1;
            end else begin
              o_saida = i_saida - UM;
            end
          end
        end
        default: begin
          o_fim = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/contador_crescente_decrescente_param.sv
// rtl/contador_crescente_decrescente_param.sv - bounded up/down/bounce counter; load port under CONTADOR_CARGA_EN
module contador_crescente_decrescente_param
  import contador_pkg::*;
#(
  parameter int LARGURA    = 4,
  parameter int LIMITE_MIN = 0,
  parameter int LIMITE_MAX = 2**LARGURA - 1
) (
  input logic clock,
  input logic reset,
  contador_crescente_decrescente_param_if.slave bus
);

  localparam logic [LARGURA-1:0] L_MIN = LARGURA'(LIMITE_MIN);
  localparam logic [LARGURA-1:0] L_MAX = LARGURA'(LIMITE_MAX);

  generate
    if (LARGURA < 2 || LIMITE_MIN < 0 || LIMITE_MIN >= LIMITE_MAX ||
        LIMITE_MAX > 2**LARGURA - 1) begin : g_param_invalido
      $error("contador: need LARGURA >= 2 and 0 <= LIMITE_MIN < LIMITE_MAX <= 2**LARGURA-1");
    end
  endgenerate

  logic [LARGURA-1:0] r_saida;
  logic               r_direcao;
  logic               r_fim;

  logic [LARGURA-1:0] w_prox_saida;
  logic               w_prox_direcao;
  logic               w_prox_fim;

  contador_proximo #(
    .LARGURA    (LARGURA),
    .LIMITE_MIN (LIMITE_MIN),
    .LIMITE_MAX (LIMITE_MAX)
  ) u_proximo (
    .i_saida    (r_saida),
    .i_direcao  (r_direcao),
    .i_habilita (bus.habilita),
    .i_modo     (bus.modo),
    .o_saida    (w_prox_saida),
    .o_direcao  (w_prox_direcao),
    .o_fim      (w_prox_fim)
  );

`ifdef CONTADOR_CARGA_EN
  logic [LARGURA-1:0] w_carga_limitada;

  // Clamp the load value into the count window so saida never leaves it.
  always_comb begin
    w_carga_limitada = bus.valor_carga;
    if (bus.valor_carga < L_MIN) begin
      w_carga_limitada = L_MIN;
    end else if (bus.valor_carga > L_MAX) begin
      w_carga_limitada = L_MAX;
    end
  end
`endif

  // State registers: reset beats load, load beats normal counting.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_saida   <= L_MIN;
      r_direcao <= DIR_SOBE;
      r_fim     <= 1'b0;
    end
`ifdef CONTADOR_CARGA_EN
    else if (bus.carga) begin
      r_saida <= w_carga_limitada;
      r_fim   <= 1'b0;
    end
`endif
    else begin
      r_saida   <= w_prox_saida;
      r_direcao <= w_prox_direcao;
      r_fim     <= w_prox_fim;
    end
  end

  assign bus.saida   = r_saida;
  assign bus.direcao = r_direcao;
  assign bus.fim     = r_fim;

endmodule

// File: tb/tb_contador_crescente_decrescente_param.sv
// tb/tb_contador_crescente_decrescente_param.sv - scoreboard bench for two counter configurations
module tb_contador_crescente_decrescente_param;
  import contador_pkg::*;

  logic clock = 1'b0;
  logic reset_a;
  logic reset_b;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int    sel;
    int    due;
    int    saida;
    int    dir;
    int    fim;
    string nome;
  } esperado_t;

  esperado_t sb[$];

  contador_crescente_decrescente_param_if #(.LARGURA(4)) ia ();
  contador_crescente_decrescente_param_if #(.LARGURA(6)) ib ();

  contador_crescente_decrescente_param #(
    .LARGURA(4)
  ) dut_a (
    .clock (clock),
    .reset (reset_a),
    .bus   (ia)
  );

  contador_crescente_decrescente_param #(
    .LARGURA    (6),
    .LIMITE_MIN (10),
    .LIMITE_MAX (20)
  ) dut_b (
    .clock (clock),
    .reset (reset_b),
    .bus   (ib)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Edge counter used to time-stamp expectations.
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: after each edge, check every expectation that has come due.
  always begin
    @(posedge clock);
    #3;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      esperado_t e;
      int        s;
      int        d;
      int        f;
      logic      x;
      e = sb.pop_front();
      if (e.sel == 0) begin
        s = int'(ia.saida);
        d = int'(ia.direcao);
        f = int'(ia.fim);
        x = $isunknown({ia.saida, ia.direcao, ia.fim});
      end else begin
        s = int'(ib.saida);
        d = int'(ib.direcao);
        f = int'(ib.fim);
        x = $isunknown({ib.saida, ib.direcao, ib.fim});
      end
      checks++;
      if (x || s != e.saida || d != e.dir || f != e.fim) begin
        errors++;
        $display("FAIL %s (dut %0d, cycle %0d): got saida=%0d direcao=%0d fim=%0d unknown=%0b, expected saida=%0d direcao=%0d fim=%0d",
                 e.nome, e.sel, cyc, s, d, f, x, e.saida, e.dir, e.fim);
      end
    end
  end

  task automatic esperar(input int sel, input int es, input int ed, input int ef, input string nome);
    esperado_t e;
    e.sel   = sel;
    e.due   = cyc + 1;
    e.saida = es;
    e.dir   = ed;
    e.fim   = ef;
    e.nome  = nome;
    sb.push_back(e);
  endtask

  // One clocked step: apply inputs just after an edge, expect the result of the next edge.
  task automatic passo(input int sel, input logic rst, input logic hab, input modo_t m,
                       input int es, input int ed, input int ef, input string nome);
    @(posedge clock);
    #1;
    if (sel == 0) begin
      reset_a     = rst;
      ia.habilita = hab;
      ia.modo     = m;
`ifdef CONTADOR_CARGA_EN
      ia.carga    = 1'b0;
`endif
    end else begin
      reset_b     = rst;
      ib.habilita = hab;
      ib.modo     = m;
`ifdef CONTADOR_CARGA_EN
      ib.carga    = 1'b0;
`endif
    end
    esperar(sel, es, ed, ef, nome);
  endtask

`ifdef CONTADOR_CARGA_EN
  // Load step with enable and an arbitrary mode active, to show load priority.
  task automatic carrega(input int sel, input logic rst, input int val,
                         input int es, input int ed, input string nome);
    @(posedge clock);
    #1;
    if (sel == 0) begin
      reset_a        = rst;
      ia.habilita    = 1'b1;
      ia.modo        = MODO_CRESCENTE;
      ia.carga       = 1'b1;
      ia.valor_carga = 4'(val);
    end else begin
      reset_b        = rst;
      ib.habilita    = 1'b1;
      ib.modo        = MODO_CRESCENTE;
      ib.carga       = 1'b1;
      ib.valor_carga = 6'(val);
    end
    esperar(sel, es, ed, 0, nome);
  endtask
`endif

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    reset_a     = 1'b0;
    reset_b     = 1'b0;
    ia.habilita = 1'b0;
    ia.modo     = MODO_CRESCENTE;
    ib.habilita = 1'b0;
    ib.modo     = MODO_CRESCENTE;
`ifdef CONTADOR_CARGA_EN
    ia.carga       = 1'b0;
    ia.valor_carga = '0;
    ib.carga       = 1'b0;
    ib.valor_carga = '0;
`endif

    // DUT A: reset, full up count with wrap, pause after wrap.
    passo(0, 0, 1, MODO_CRESCENTE, 0, 1, 0, "reset_a");
    passo(0, 0, 1, MODO_CRESCENTE, 0, 1, 0, "reset_a_hold");
    for (int i = 1; i <= 16; i++)
      passo(0, 1, 1, MODO_CRESCENTE, i % 16, 1, (i == 16) ? 1 : 0, "crescente");
    passo(0, 1, 0, MODO_CRESCENTE, 0, 1, 0, "pausa_apos_fim");
    passo(0, 1, 1, MODO_DECRESCENTE, 15, 0, 1, "decrescente_wrap");
    passo(0, 1, 1, MODO_DECRESCENTE, 14, 0, 0, "decrescente");

    // DUT A: bounce from reset.
    passo(0, 0, 0, MODO_CRESCENTE, 0, 1, 0, "reset_vev");
    for (int i = 1; i <= 15; i++)
      passo(0, 1, 1, MODO_VAI_E_VEM, i, 1, 0, "vev_sobe");
    passo(0, 1, 1, MODO_VAI_E_VEM, 14, 0, 1, "vev_vira_topo");
    for (int i = 13; i >= 0; i--)
      passo(0, 1, 1, MODO_VAI_E_VEM, i, 0, 0, "vev_desce");
    passo(0, 1, 1, MODO_VAI_E_VEM, 1, 1, 1, "vev_vira_base");
    passo(0, 1, 1, MODO_VAI_E_VEM, 2, 1, 0, "vev_sobe_de_novo");

    // DUT A: hold, reserved mode and mode changes at 7.
    passo(0, 0, 0, MODO_CRESCENTE, 0, 1, 0, "reset_modos");
    for (int i = 1; i <= 7; i++)
      passo(0, 1, 1, MODO_CRESCENTE, i, 1, 0, "ate_7");
    for (int i = 0; i < 3; i++)
      passo(0, 1, 0, MODO_CRESCENTE, 7, 1, 0, "habilita_0");
    for (int i = 0; i < 3; i++)
      passo(0, 1, 1, MODO_RESERVADO, 7, 1, 0, "modo_reservado");
    passo(0, 1, 1, MODO_DECRESCENTE, 6, 0, 0, "troca_para_desce");
    passo(0, 1, 1, MODO_CRESCENTE, 7, 1, 0, "troca_para_sobe");
    passo(0, 1, 1, MODO_VAI_E_VEM, 8, 1, 0, "vev_mantem_sobe");
    passo(0, 1, 1, MODO_DECRESCENTE, 7, 0, 0, "desce_antes_vev");
    passo(0, 1, 1, MODO_VAI_E_VEM, 6, 0, 0, "vev_mantem_desce");

    // DUT A: reset mid-count has priority, count resumes after release.
    passo(0, 0, 0, MODO_CRESCENTE, 0, 1, 0, "reset_meio");
    for (int i = 1; i <= 9; i++)
      passo(0, 1, 1, MODO_CRESCENTE, i, 1, 0, "ate_9");
    passo(0, 1, 1, MODO_DECRESCENTE, 8, 0, 0, "desce_para_8");
`ifdef CONTADOR_CARGA_EN
    carrega(0, 0, 12, 0, 1, "reset_vs_carga_1");
    carrega(0, 0, 12, 0, 1, "reset_vs_carga_2");
`else
    passo(0, 0, 1, MODO_DECRESCENTE, 0, 1, 0, "reset_prioridade_1");
    passo(0, 0, 1, MODO_DECRESCENTE, 0, 1, 0, "reset_prioridade_2");
`endif
    passo(0, 1, 1, MODO_CRESCENTE, 1, 1, 0, "retoma_1");
    passo(0, 1, 1, MODO_CRESCENTE, 2, 1, 0, "retoma_2");
`ifdef CONTADOR_CARGA_EN
    carrega(0, 1, 12, 12, 1, "carga_a_12");
    passo(0, 1, 1, MODO_CRESCENTE, 13, 1, 0, "apos_carga_a");
`endif
    passo(0, 1, 0, MODO_CRESCENTE, -1, -1, -1, "a_parado");
    void'(sb.pop_back());

    // DUT B (window 10..20): down wraps, up wrap, bounce turn at the top.
    passo(1, 0, 0, MODO_CRESCENTE, 10, 1, 0, "reset_b");
    passo(1, 1, 1, MODO_DECRESCENTE, 20, 0, 1, "b_desce_wrap_min");
    for (int i = 19; i >= 10; i--)
      passo(1, 1, 1, MODO_DECRESCENTE, i, 0, 0, "b_desce");
    passo(1, 1, 1, MODO_DECRESCENTE, 20, 0, 1, "b_desce_wrap");
    passo(1, 1, 1, MODO_CRESCENTE, 10, 1, 1, "b_sobe_wrap");
    for (int i = 11; i <= 20; i++)
      passo(1, 1, 1, MODO_CRESCENTE, i, 1, 0, "b_sobe");
    passo(1, 1, 1, MODO_VAI_E_VEM, 19, 0, 1, "b_vev_vira_topo");
    passo(1, 1, 1, MODO_VAI_E_VEM, 18, 0, 0, "b_vev_desce");
`ifdef CONTADOR_CARGA_EN
    carrega(1, 1, 25, 20, 0, "b_carga_acima");
    for (int i = 19; i >= 10; i--)
      passo(1, 1, 1, MODO_DECRESCENTE, i, 0, 0, "b_desce_apos_carga");
    passo(1, 1, 1, MODO_DECRESCENTE, 20, 0, 1, "b_volta_20");
    carrega(1, 1, 3, 10, 0, "b_carga_abaixo");
    carrega(1, 1, 15, 15, 0, "b_carga_dentro");
    carrega(1, 0, 15, 10, 1, "b_reset_vs_carga");
`endif

    repeat (3) @(posedge clock);
    #4;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
